// File: rtl/gate_bist.sv
// Built-in self-test for a single-input gate (buffer or inverter): drives an
// alternating 0/1 stimulus, lets it settle, checks the response and counts mismatches.
module gate_bist #(
  parameter int NUM_VECTORS   = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       expect_inv,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_IDX    = 8'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic        r_dut_a, w_dut_a_next;
  logic        r_pass, w_pass_next;
  logic [7:0]  r_err_count, w_err_count_next;
  logic [7:0]  r_vec_idx, w_vec_idx_next;
  logic [3:0]  r_settle_cnt, w_settle_cnt_next;
  logic        r_exp_inv, w_exp_inv_next;

  logic        w_expected;
  logic        w_mismatch;
  logic [7:0]  w_err_inc;
  logic [7:0]  w_idx_inc;

  assign w_expected = r_exp_inv ? ~r_dut_a : r_dut_a;
  assign w_mismatch = (dut_y != w_expected);
  // Saturate rather than wrap so a heavily faulty gate never reads as clean.
  assign w_err_inc  = (w_mismatch && (r_err_count != 8'hFF)) ? r_err_count + 8'd1 : r_err_count;
  assign w_idx_inc  = r_vec_idx + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dut_a      <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= 8'd0;
      r_vec_idx    <= 8'd0;
      r_settle_cnt <= 4'd0;
      r_exp_inv    <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_dut_a      <= w_dut_a_next;
      r_pass       <= w_pass_next;
      r_err_count  <= w_err_count_next;
      r_vec_idx    <= w_vec_idx_next;
      r_settle_cnt <= w_settle_cnt_next;
      r_exp_inv    <= w_exp_inv_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_dut_a_next      = r_dut_a;
    w_pass_next       = r_pass;
    w_err_count_next  = r_err_count;
    w_vec_idx_next    = r_vec_idx;
    w_settle_cnt_next = r_settle_cnt;
    w_exp_inv_next    = r_exp_inv;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next      = S_SETTLE;
          w_dut_a_next      = 1'b0;
          w_pass_next       = 1'b0;
          w_err_count_next  = 8'd0;
          w_vec_idx_next    = 8'd0;
          w_settle_cnt_next = 4'd0;
          w_exp_inv_next    = expect_inv;
        end
      end
      S_SETTLE: begin
        w_settle_cnt_next = r_settle_cnt + 4'd1;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_err_count_next = w_err_inc;
        if (r_vec_idx == LAST_IDX) begin
          // Pass must include the mismatch of this final check.
          w_state_next = S_DONE;
          w_pass_next  = (w_err_inc == 8'd0);
        end else begin
          w_state_next      = S_SETTLE;
          w_vec_idx_next    = w_idx_inc;
          w_dut_a_next      = w_idx_inc[0];
          w_settle_cnt_next = 4'd0;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign dut_a     = r_dut_a;
  assign busy      = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign vec_idx   = r_vec_idx;

endmodule
